sum_accumulator: RTL
====================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 The module SHALL have parameter IN_WIDTH, default 2, width of each per-cycle count input.
REQ-002 The module SHALL have parameter CNT_WIDTH, default 4, width of the signed internal accumulator (two's complement).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 en  input  1  accumulate enable.
REQ-006 clr  input  1  synchronous clear of accumulator and outputs.
REQ-007 sum_p  input  IN_WIDTH  unsigned count of 1s on positive-channel bitstreams this cycle (driven by the upstream adder tree).
REQ-008 sum_n  input  IN_WIDTH  unsigned count of 1s on negative-channel bitstreams this cycle.
REQ-009 bit_p  output  1  registered positive-channel output bitstream.
REQ-010 bit_n  output  1  registered negative-channel output bitstream.
REQ-011 count  output  CNT_WIDTH  registered signed accumulator value (residue after emission).
REQ-012 sat  output  1  registered one-cycle pulse, accumulator clamped this update.

Function
REQ-013 All outputs SHALL be registered; an input sampled at edge k SHALL affect outputs visible after edge k (latency 1 cycle).
REQ-014 Priority per edge SHALL be: clr, then en, then hold.
REQ-015 clr=1: count<=0, bit_p<=0, bit_n<=0, sat<=0, regardless of en.
REQ-016 en=0 and clr=0: count holds; bit_p, bit_n, sat <= 0.
REQ-017 en=1: compute t = count + sum_p - sum_n at CNT_WIDTH+IN_WIDTH+1 bits signed, with no intermediate overflow.
REQ-018 If t >= 1: bit_p<=1, bit_n<=0, u = t-1.
REQ-019 Else if t <= -1: bit_n<=1, bit_p<=0, u = t+1.
REQ-020 Else (t == 0): bit_p<=0, bit_n<=0, u = 0.
REQ-021 bit_p and bit_n SHALL never be 1 in the same cycle.
REQ-022 At most one output bit SHALL be emitted per cycle; surplus is carried in count.
REQ-023 If u > 2^(CNT_WIDTH-1)-1: count <= 2^(CNT_WIDTH-1)-1, sat<=1.
REQ-024 If u < -2^(CNT_WIDTH-1): count <= -2^(CNT_WIDTH-1), sat<=1.
REQ-025 Otherwise count <= u, sat<=0.
REQ-026 Clamping SHALL NOT suppress the bit emitted in the same cycle.
REQ-027 sum_p == sum_n with count == 0 SHALL produce no output bits and leave count at 0.
REQ-028 Long-run density of bit_p minus bit_n SHALL equal the density of (sum_p - sum_n) whenever no saturation occurs.

Reset
REQ-029 nRST low SHALL immediately (asynchronously) force count=0, bit_p=0, bit_n=0, sat=0.
REQ-030 While nRST is low, inputs SHALL be ignored; the first update SHALL occur on the first rising edge after nRST deasserts.
REQ-031 Reset asserted mid-accumulation SHALL discard the residue; no bits are emitted for it after release.

Verification (IN_WIDTH=2, CNT_WIDTH=4, range -8..7)
REQ-032 Reset then en=1, sum_p=2, sum_n=0 for 8 cycles -> bit_p=1 every cycle; count = 1,2,...,7 after cycles 1..7; cycle 8 count stays 7, sat=1 for that cycle only.
REQ-033 en=1, sum_n=2, sum_p=0 from count=0 for 9 cycles -> bit_n=1 every cycle; count reaches -8 at cycle 8 with sat=0; cycle 9 count=-8, sat=1.
REQ-034 en=1, sum_p alternates 1,0,1,0 with sum_n=0 -> bit_p = 1,0,1,0; count stays 0; sum_p=sum_n=1 -> no bits, count 0.
REQ-035 Accumulate to count=5, then en=0 for 3 cycles -> count holds 5, all bits 0; then clr=1 with en=1, sum_p=3 -> count=0, bit_p=0.
REQ-036 Accumulate to count=4, assert nRST low between edges -> outputs 0 immediately; release, sum_p=sum_n=0 -> count stays 0, no bits.

Source files
------------

// File: rtl/sum_accumulator.sv
// Signed accumulator that turns per-cycle (sum_p - sum_n) counts into paired
// positive/negative output bitstreams, emitting at most one bit per cycle and
// carrying the surplus as a saturating residue.
// Latency: 1 cycle (all outputs registered). Backpressure: none, updates every enabled cycle.
// Ports:
//   CLK, nRST     clock, asynchronous active-low reset
//   en, clr       accumulate enable, synchronous clear (clr has priority)
//   sum_p, sum_n  unsigned per-cycle counts of 1s on positive / negative channels
//   bit_p, bit_n  registered output bitstreams (never both high)
//   count         registered signed residue
//   sat           registered one-cycle pulse when the residue was clamped
module sum_accumulator #(
  parameter int IN_WIDTH  = 2,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 en,
  input  logic                 clr,
  input  logic [IN_WIDTH-1:0]  sum_p,
  input  logic [IN_WIDTH-1:0]  sum_n,
  output logic                 bit_p,
  output logic                 bit_n,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 sat
);

  // Working width wide enough that count + sum_p - sum_n cannot overflow.
  localparam int TW = CNT_WIDTH + IN_WIDTH + 1;
  localparam logic signed [TW-1:0] MAX_V = TW'((1 << (CNT_WIDTH - 1)) - 1);
  localparam logic signed [TW-1:0] MIN_V = -MAX_V - TW'(1);

  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 bit_p_q, bit_p_d;
  logic                 bit_n_q, bit_n_d;
  logic                 sat_q, sat_d;

  logic signed [TW-1:0] t_val;
  logic signed [TW-1:0] u_val;
  logic                 t_pos;
  logic                 t_neg;

  always_comb begin
    count_d = count_q;
    bit_p_d = 1'b0;
    bit_n_d = 1'b0;
    sat_d   = 1'b0;
    t_val   = {{(IN_WIDTH + 1){count_q[CNT_WIDTH-1]}}, count_q}
              + TW'(sum_p) - TW'(sum_n);
    // Sign bit and zero test avoid mixed signed/unsigned compares.
    t_neg   = t_val[TW-1];
    t_pos   = !t_val[TW-1] && (t_val != '0);
    u_val   = '0;

    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (t_pos) begin
        bit_p_d = 1'b1;
        u_val   = t_val - TW'(1);
      end else if (t_neg) begin
        bit_n_d = 1'b1;
        u_val   = t_val + TW'(1);
      end else begin
        u_val   = '0;
      end

      // Clamp only affects the residue; the bit chosen above is still emitted.
      if (u_val > MAX_V) begin
        count_d = MAX_V[CNT_WIDTH-1:0];
        sat_d   = 1'b1;
      end else if (u_val < MIN_V) begin
        count_d = MIN_V[CNT_WIDTH-1:0];
        sat_d   = 1'b1;
      end else begin
        count_d = u_val[CNT_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count_q <= '0;
      bit_p_q <= 1'b0;
      bit_n_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      bit_p_q <= bit_p_d;
      bit_n_q <= bit_n_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign bit_p = bit_p_q;
  assign bit_n = bit_n_q;
  assign sat   = sat_q;

endmodule
